// File: rtl/mem_1r1w_fifo.sv
// First-word-fall-through ready/valid FIFO built around an external 1R1W RAM
// with one cycle of registered read latency, hidden behind a 2-entry output buffer.
module mem_1r1w_fifo #(
    parameter int DEPTH       = 48,
    parameter int WIDTH       = 64,
    parameter int ADDR_WIDTH  = 6,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [WIDTH-1:0]       enq_bits,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [WIDTH-1:0]       deq_bits,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [ADDR_WIDTH-1:0]  mem_W0_addr,
    output logic                   mem_W0_en,
    output logic [WIDTH-1:0]       mem_W0_data,
    output logic [ADDR_WIDTH-1:0]  mem_R0_addr,
    output logic                   mem_R0_en,
    input  logic [WIDTH-1:0]       mem_R0_data
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [COUNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic                   inflight_q, inflight_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;
    logic [WIDTH-1:0]       buf0_q, buf0_d;
    logic [WIDTH-1:0]       buf1_q, buf1_d;

    logic                   enq_fire_s;
    logic                   deq_fire_s;
    logic                   rd_s;
    logic [2:0]             occ_s;
    logic [1:0]             buf_cnt_shift_s;
    logic [COUNT_WIDTH-1:0] count_s;

    assign count_s     = mem_cnt_q + COUNT_WIDTH'(inflight_q) + COUNT_WIDTH'(buf_cnt_q);
    assign count       = count_s;
    assign enq_ready   = (count_s < DEPTH_C);
    assign deq_valid   = (buf_cnt_q != 2'd0);
    assign deq_bits    = buf0_q;
    assign mem_W0_addr = wptr_q;
    assign mem_W0_data = enq_bits;
    assign mem_W0_en   = enq_fire_s;
    assign mem_R0_addr = rptr_q;
    assign mem_R0_en   = rd_s;

    // Handshakes, read issue, pointer/counter updates and output buffer refill.
    always_comb begin
        enq_fire_s      = enq_valid & enq_ready & ~reset;
        deq_fire_s      = deq_valid & deq_ready;
        // Occupancy the buffer would have next cycle without a new read.
        occ_s           = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire_s};
        rd_s            = ~reset & (mem_cnt_q != {COUNT_WIDTH{1'b0}}) & (occ_s <= 3'd1);

        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        mem_cnt_d       = mem_cnt_q + COUNT_WIDTH'(enq_fire_s) - COUNT_WIDTH'(rd_s);
        inflight_d      = rd_s;
        buf0_d          = buf0_q;
        buf1_d          = buf1_q;
        buf_cnt_shift_s = buf_cnt_q - {1'b0, deq_fire_s};
        buf_cnt_d       = buf_cnt_shift_s;

        if (enq_fire_s) begin
            wptr_d = (wptr_q == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : wptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_s) begin
            rptr_d = (rptr_q == LAST_PTR) ? {ADDR_WIDTH{1'b0}} : rptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end

        if (deq_fire_s) begin
            buf0_d = buf1_q;
        end else begin
            buf0_d = buf0_q;
        end

        // Returning RAM data lands in the first slot left free after the shift.
        if (inflight_q) begin
            if (buf_cnt_shift_s == 2'd0) begin
                buf0_d = mem_R0_data;
            end else begin
                buf1_d = mem_R0_data;
            end
            buf_cnt_d = buf_cnt_shift_s + 2'd1;
        end else begin
            buf_cnt_d = buf_cnt_shift_s;
        end
    end

    // State registers; reset discards contents and drops any read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= {ADDR_WIDTH{1'b0}};
            rptr_q     <= {ADDR_WIDTH{1'b0}};
            mem_cnt_q  <= {COUNT_WIDTH{1'b0}};
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= {WIDTH{1'b0}};
            buf1_q     <= {WIDTH{1'b0}};
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_mem_1r1w_fifo.sv
// Directed bench for mem_1r1w_fifo with a behavioural 1R1W RAM behind it.
module tb_mem_1r1w_fifo;

    localparam int DEPTH = 48;
    localparam int WIDTH = 64;
    localparam int AW    = 6;
    localparam int CW    = 6;

    logic             clock;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0]    count;
    logic [AW-1:0]    mem_W0_addr;
    logic             mem_W0_en;
    logic [WIDTH-1:0] mem_W0_data;
    logic [AW-1:0]    mem_R0_addr;
    logic             mem_R0_en;
    logic [WIDTH-1:0] mem_R0_data;

    logic [WIDTH-1:0] ram [0:63];

    int n_tests;
    int n_fail;

    mem_1r1w_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data),
        .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Simple dual-port RAM with one cycle of registered read latency.
    always @(posedge clock) begin
        if (mem_W0_en) ram[mem_W0_addr] <= mem_W0_data;
        if (mem_R0_en) mem_R0_data <= ram[mem_R0_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int k;
        int budget;
        int enq_idx;
        int deq_idx;
        logic stalled_prev;
        logic [2:0] occ;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        enq_valid = 1'b1;
        enq_bits  = 64'h0;
        deq_ready = 1'b0;
        #1;
        check_eq("rst_count", count, 64'd0);
        check_eq("rst_deq_valid", deq_valid, 64'd0);
        check_eq("rst_enq_ready", enq_ready, 64'd1);
        check_eq("rst_w0_en", mem_W0_en, 64'd0);
        check_eq("rst_r0_en", mem_R0_en, 64'd0);
        enq_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Single enqueue: visible three cycles later.
        cyc(); enq_valid = 1'b1; enq_bits = 64'h1234; #1;
        check_eq("single_c0_w0_en", mem_W0_en, 64'd1);
        cyc(); enq_valid = 1'b0; #1;
        check_eq("single_c1_count", count, 64'd1);
        check_eq("single_c1_valid", deq_valid, 64'd0);
        check_eq("single_c1_r0_en", mem_R0_en, 64'd1);
        cyc(); #1;
        check_eq("single_c2_count", count, 64'd1);
        check_eq("single_c2_valid", deq_valid, 64'd0);
        cyc(); #1;
        check_eq("single_c3_valid", deq_valid, 64'd1);
        check_eq("single_c3_bits", deq_bits, 64'h1234);
        check_eq("single_c3_count", count, 64'd1);
        deq_ready = 1'b1;
        cyc(); deq_ready = 1'b0; #1;
        check_eq("single_empty_count", count, 64'd0);
        check_eq("single_empty_valid", deq_valid, 64'd0);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(); enq_valid = 1'b1; enq_bits = 64'(i); #1;
            check_eq("fill_enq_ready", enq_ready, 64'd1);
        end
        cyc(); enq_bits = 64'd99; #1;
        check_eq("full_enq_ready", enq_ready, 64'd0);
        check_eq("full_count", count, 64'd48);
        check_eq("full_w0_en", mem_W0_en, 64'd0);
        cyc(); #1;
        check_eq("full_hold_count", count, 64'd48);
        check_eq("full_hold_bits", deq_bits, 64'd0);

        // Dequeue and enqueue requested together while full.
        cyc(); deq_ready = 1'b1; enq_bits = 64'd100; #1;
        check_eq("fullx_deq_valid", deq_valid, 64'd1);
        check_eq("fullx_deq_bits", deq_bits, 64'd0);
        check_eq("fullx_enq_ready", enq_ready, 64'd0);
        cyc(); #1;
        check_eq("fullx_b_count", count, 64'd47);
        check_eq("fullx_b_enq_ready", enq_ready, 64'd1);
        check_eq("fullx_b_w0_en", mem_W0_en, 64'd1);
        check_eq("fullx_b_bits", deq_bits, 64'd1);
        cyc(); enq_valid = 1'b0; #1;
        check_eq("fullx_c_count", count, 64'd47);

        k = 2;
        budget = 0;
        while (k < 49 && budget < 200) begin
            if (deq_valid) begin
                check_eq("drain_bits", deq_bits, (k < 48) ? 64'(k) : 64'd100);
                k++;
            end
            if (k < 49) begin
                cyc(); #1;
            end
            budget++;
        end
        check_eq("drain_words", 64'(k), 64'd49);
        cyc(); deq_ready = 1'b0; #1;
        check_eq("drain_empty_count", count, 64'd0);

        // Full-rate streaming across several pointer wraps.
        for (int c = 0; c < 206; c++) begin
            cyc();
            enq_valid = (c < 200);
            enq_bits  = 64'h5000 + 64'(c);
            deq_ready = 1'b1;
            #1;
            check_eq("stream_valid", deq_valid, (c >= 3 && c < 203) ? 64'd1 : 64'd0);
            if (c >= 3 && c < 203) check_eq("stream_bits", deq_bits, 64'h5000 + 64'(c - 3));
            if (c == 100) check_eq("stream_count", count, 64'd3);
        end
        cyc(); enq_valid = 1'b0; deq_ready = 1'b0; #1;
        check_eq("stream_empty_count", count, 64'd0);

        // Random consumer backpressure.
        enq_idx = 0;
        deq_idx = 0;
        budget = 0;
        stalled_prev = 1'b0;
        while (deq_idx < 100 && budget < 3000) begin
            cyc();
            enq_valid = (enq_idx < 100);
            enq_bits  = 64'h7000 + 64'(enq_idx);
            deq_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled_prev) check_eq("rand_stall_valid", deq_valid, 64'd1);
            if (deq_valid) check_eq("rand_head_bits", deq_bits, 64'h7000 + 64'(deq_idx));
            occ = {1'b0, dut.buf_cnt_q} + {2'b00, dut.inflight_q};
            if (occ == 3'd2 && !(deq_valid && deq_ready)) check_eq("rand_rd_guard", mem_R0_en, 64'd0);
            if (deq_valid && deq_ready) deq_idx++;
            if (enq_valid && enq_ready) enq_idx++;
            stalled_prev = deq_valid && !deq_ready;
            budget++;
        end
        check_eq("rand_words", 64'(deq_idx), 64'd100);
        cyc(); enq_valid = 1'b0; deq_ready = 1'b0; #1;
        check_eq("rand_empty_count", count, 64'd0);

        // Asynchronous reset with entries held and a read in flight.
        for (int i = 0; i < 5; i++) begin
            cyc(); enq_valid = 1'b1; enq_bits = 64'h900 + 64'(i); #1;
        end
        cyc(); enq_valid = 1'b0; #1;
        check_eq("pre_rst_count", count, 64'd5);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_count", count, 64'd0);
        check_eq("mid_rst_valid", deq_valid, 64'd0);
        check_eq("mid_rst_enq_ready", enq_ready, 64'd1);
        cyc(); reset = 1'b0; #1;
        cyc(); enq_valid = 1'b1; enq_bits = 64'hAA; #1;
        cyc(); enq_valid = 1'b0; #1;
        budget = 0;
        while (!deq_valid && budget < 10) begin
            cyc(); #1;
            budget++;
        end
        check_eq("post_rst_valid", deq_valid, 64'd1);
        check_eq("post_rst_bits", deq_bits, 64'hAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
